// File: rtl/button_pulse_conditioner.sv
// Debounce and auto-repeat conditioner for the up/down current-select buttons.
// Each button produces one pulse on press, then repeat pulses while it is held.
module button_pulse_conditioner #(
   parameter int TMR_W           = 26,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_RATE     = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   input  logic en,
   output logic up_pulse,
   output logic down_pulse,
   output logic up_level,
   output logic down_level
);

   localparam logic [TMR_W-1:0] DB_LAST   = TMR_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] RD_LAST   = TMR_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
   localparam logic [TMR_W-1:0] RR_LAST   = TMR_W'(REPEAT_RATE - 1);
   localparam bit               REPEAT_ON = (REPEAT_DELAY != 0);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_e;

   logic [1:0] raw_bus;
   logic [1:0] level_bus;
   logic [1:0] pulse_bus;
   logic       both_held;

   assign raw_bus   = {btn_down_raw, btn_up_raw};
   assign both_held = level_bus[0] & level_bus[1];

   // Index 0 is the up button, index 1 the down button.
   for (genvar b = 0; b < 2; b++) begin : g_btn
      logic             s1;
      logic             s2;
      logic             level;
      logic             pulse_q;
      logic             fire;
      logic [TMR_W-1:0] db_cnt;
      logic [TMR_W-1:0] rt;
      logic [TMR_W-1:0] rt_next;
      rep_state_e       state;
      rep_state_e       state_next;

      // A level change is accepted only after s2 disagrees with it for DEBOUNCE_CYCLES edges in a row.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
         end else begin
            s1 <= raw_bus[b];
            s2 <= s1;
            if (s2 == level) begin
               db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
               level  <= s2;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + TMR_W'(1);
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state   <= IDLE;
            rt      <= '0;
            pulse_q <= 1'b0;
         end else begin
            state   <= state_next;
            rt      <= rt_next;
            pulse_q <= fire & en & ~both_held;
         end
      end

      // Masked events still advance the schedule, so they are dropped rather than deferred.
      always_comb begin
         state_next = state;
         rt_next    = rt;
         fire       = 1'b0;
         case (state)
            IDLE: begin
               rt_next = '0;
               if (level) begin
                  fire       = 1'b1;
                  state_next = HOLD;
               end
            end
            HOLD: begin
               if (!level) begin
                  state_next = IDLE;
                  rt_next    = '0;
               end else if (REPEAT_ON) begin
                  if (rt == RD_LAST) begin
                     fire       = 1'b1;
                     rt_next    = '0;
                     state_next = REPEAT;
                  end else begin
                     rt_next = rt + TMR_W'(1);
                  end
               end
            end
            REPEAT: begin
               if (!level) begin
                  state_next = IDLE;
                  rt_next    = '0;
               end else if (rt == RR_LAST) begin
                  fire    = 1'b1;
                  rt_next = '0;
               end else begin
                  rt_next = rt + TMR_W'(1);
               end
            end
            default: begin
               state_next = IDLE;
               rt_next    = '0;
            end
         endcase
      end

      assign level_bus[b] = level;
      assign pulse_bus[b] = pulse_q;
   end

   assign up_pulse   = pulse_bus[0];
   assign down_pulse = pulse_bus[1];
   assign up_level   = level_bus[0];
   assign down_level = level_bus[1];

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with short timers (D=4, delay=20, rate=8).
// Tick index 1 of each window is the edge where the synchronizer captures the new raw level.
module tb_button_pulse_conditioner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_up_raw = 1'b0;
   logic btn_down_raw = 1'b0;
   logic en = 1'b1;
   logic up_pulse;
   logic down_pulse;
   logic up_level;
   logic down_level;

   int totalCount = 0;
   int badCount = 0;
   int upExp[$];
   int downExp[$];
   int upLvlEdge = 0;
   logic upLvlVal = 1'b1;

   button_pulse_conditioner #(
      .TMR_W(8),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(20),
      .REPEAT_RATE(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_up_raw(btn_up_raw),
      .btn_down_raw(btn_down_raw),
      .en(en),
      .up_pulse(up_pulse),
      .down_pulse(down_pulse),
      .up_level(up_level),
      .down_level(down_level)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      totalCount++;
      if (obs !== exp) begin
         badCount++;
         $display("[TB] FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic up, input logic down, input logic enable);
      btn_up_raw   = up;
      btn_down_raw = down;
      en           = enable;
   endtask

   function automatic bit inQ(input int q[$], input int v);
      foreach (q[j]) if (q[j] == v) return 1'b1;
      return 1'b0;
   endfunction

   // Steps ticks base+1..base+n, checking both pulses (and optionally up_level) after each edge.
   task automatic runWindow(input string tag, input int base, input int n);
      for (int i = base + 1; i <= base + n; i++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("%s up_pulse t%0d", tag, i), up_pulse, inQ(upExp, i));
         checkOutput($sformatf("%s down_pulse t%0d", tag, i), down_pulse, inQ(downExp, i));
         if (upLvlEdge > 0)
            checkOutput($sformatf("%s up_level t%0d", tag, i), up_level,
                        (i >= upLvlEdge) ? upLvlVal : ~upLvlVal);
      end
   endtask

   task automatic setExp(input int lvlEdge, input logic lvlVal);
      upExp.delete();
      downExp.delete();
      upLvlEdge = lvlEdge;
      upLvlVal  = lvlVal;
   endtask

   initial begin
      #2;
      checkOutput("reset up_pulse", up_pulse, 1'b0);
      checkOutput("reset down_pulse", down_pulse, 1'b0);
      checkOutput("reset up_level", up_level, 1'b0);
      checkOutput("reset down_level", down_level, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      setExp(0, 1'b1);
      runWindow("idle", 0, 4);

      // Clean press held: press pulse at 7, repeats at +20 then every 8.
      applyStimulus(1'b1, 1'b0, 1'b1);
      setExp(6, 1'b1);
      upExp = '{7, 27, 35, 43, 51, 59};
      runWindow("hold", 0, 66);

      // Release: the repeat already due on the capture edge still fires, nothing afterwards.
      applyStimulus(1'b0, 1'b0, 1'b1);
      setExp(6, 1'b0);
      upExp = '{1};
      runWindow("release", 0, 20);

      // Down button path.
      applyStimulus(1'b0, 1'b1, 1'b1);
      setExp(0, 1'b1);
      downExp = '{7};
      runWindow("down press", 0, 8);
      checkOutput("down_level held", down_level, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      setExp(0, 1'b1);
      runWindow("down release", 8, 12);
      checkOutput("down_level released", down_level, 1'b0);

      // Bounce: short high runs never pass the filter.
      setExp(0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         runWindow("bounce hi", 0, 2);
         applyStimulus(1'b0, 1'b0, 1'b1);
         runWindow("bounce lo", 0, 2);
      end
      applyStimulus(1'b1, 1'b0, 1'b1);
      setExp(6, 1'b1);
      upExp = '{7};
      runWindow("bounce settle", 0, 10);
      applyStimulus(1'b0, 1'b0, 1'b1);
      setExp(16, 1'b0);
      runWindow("bounce release", 10, 12);

      // Both held: all pulses masked; up resumes on its original grid once down is released.
      applyStimulus(1'b1, 1'b0, 1'b1);
      setExp(6, 1'b1);
      upExp = '{7, 51, 59};
      runWindow("both", 0, 10);
      applyStimulus(1'b1, 1'b1, 1'b1);
      runWindow("both", 10, 30);
      checkOutput("both down_level", down_level, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      runWindow("both", 40, 20);
      applyStimulus(1'b0, 1'b0, 1'b1);
      setExp(66, 1'b0);
      runWindow("both release", 60, 14);

      // en masking: press while disabled, enable mid-hold, only scheduled repeats appear.
      applyStimulus(1'b1, 1'b0, 1'b0);
      setExp(6, 1'b1);
      runWindow("en off", 0, 10);
      applyStimulus(1'b1, 1'b0, 1'b1);
      upExp = '{27, 35};
      runWindow("en on", 10, 26);
      applyStimulus(1'b0, 1'b0, 1'b1);
      setExp(42, 1'b0);
      runWindow("en release", 36, 12);

      // Reset mid-hold, asserted while a repeat pulse is high.
      applyStimulus(1'b1, 1'b0, 1'b1);
      setExp(6, 1'b1);
      upExp = '{7, 27};
      runWindow("pre-reset", 0, 27);
      rst = 1'b1;
      #1;
      checkOutput("async reset up_pulse", up_pulse, 1'b0);
      checkOutput("async reset up_level", up_level, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("in reset up_pulse", up_pulse, 1'b0);
      checkOutput("in reset up_level", up_level, 1'b0);
      rst = 1'b0;
      setExp(6, 1'b1);
      upExp = '{7};
      runWindow("after reset", 0, 10);
      applyStimulus(1'b0, 1'b0, 1'b1);
      setExp(16, 1'b0);
      runWindow("after reset release", 10, 12);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
